// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM encoding,
// frame field widths and default sizing.
package imem_loader_pkg;

   localparam int unsigned BYTE_W      = 8;
   localparam int unsigned LEN_W       = 16;
   localparam int unsigned WORD_W      = 32;
   localparam int unsigned LANE_W      = 2;
   localparam int unsigned CSUM_W      = 8;

   localparam int unsigned DEF_ADDR_W  = 8;
   localparam int unsigned DEF_DEPTH   = 256;
   localparam int unsigned DEF_TIMEOUT = 50000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN_LO,
      ST_LEN_HI,
      ST_DATA,
      ST_CSUM,
      ST_DONE,
      ST_ERR
   } state_e;

   // True while a frame is being received (byte stream open, fetch held).
   function automatic logic in_frame(input state_e s);
      return s inside {ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CSUM};
   endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Loader bus: byte-stream input, instruction-memory write port and status.
// master = loader side, slave = byte source / memory / CPU side.
interface imem_loader_if
   import imem_loader_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W
);
   logic                start;
   logic                in_valid;
   logic [BYTE_W-1:0]   in_data;
   logic                in_ready;
   logic                write_en;
   logic [ADDR_W-1:0]   write_addr;
   logic [WORD_W-1:0]   write_data;
   logic                cpu_hold;
   logic                load_done;
   logic                load_err;

   modport master (
      input  start, in_valid, in_data,
      output in_ready, write_en, write_addr, write_data, cpu_hold, load_done, load_err
   );

   modport slave (
      output start, in_valid, in_data,
      input  in_ready, write_en, write_addr, write_data, cpu_hold, load_done, load_err
   );
endinterface

// File: rtl/imem_loader_asm.sv
// Byte-to-word assembler: packs little-endian bytes into 32-bit words, keeps
// the running XOR of all payload bytes and pulses word_ready after each 4th byte.
module imem_loader_asm
   import imem_loader_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clear,
   input  logic                byte_valid,
   input  logic [BYTE_W-1:0]   byte_data,
   output logic                word_ready,
   output logic [WORD_W-1:0]   word,
   output logic [CSUM_W-1:0]   csum,
   output logic                last_lane_c
);

   logic [LANE_W-1:0] lane_q, lane_d;
   logic [WORD_W-1:0] shift_q, shift_d;
   logic [CSUM_W-1:0] csum_q, csum_d;
   logic              ready_q, ready_d;

   assign last_lane_c = (lane_q == LANE_W'(3));

   // Bytes enter at the top so the first byte of a word ends up in bits [7:0].
   always_comb begin
      lane_d  = lane_q;
      shift_d = shift_q;
      csum_d  = csum_q;
      ready_d = 1'b0;
      if (clear) begin
         lane_d  = '0;
         shift_d = '0;
         csum_d  = '0;
      end else if (byte_valid) begin
         lane_d  = lane_q + LANE_W'(1);
         shift_d = {byte_data, shift_q[WORD_W-1:BYTE_W]};
         csum_d  = csum_q ^ byte_data;
         ready_d = last_lane_c;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lane_q  <= '0;
         shift_q <= '0;
         csum_q  <= '0;
         ready_q <= 1'b0;
      end else begin
         lane_q  <= lane_d;
         shift_q <= shift_d;
         csum_q  <= csum_d;
         ready_q <= ready_d;
      end
   end

   assign word_ready = ready_q;
   assign word       = shift_q;
   assign csum       = csum_q;

endmodule

// File: rtl/imem_loader.sv
// Boot/debug loader: receives a length/payload/checksum byte frame and writes
// the payload words to instruction memory, holding the CPU fetch stage meanwhile.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned ADDR_W  = DEF_ADDR_W,
   parameter int unsigned DEPTH   = DEF_DEPTH,
   parameter int unsigned TIMEOUT = DEF_TIMEOUT
)(
   input  logic          clk,
   input  logic          rst_n,
   imem_loader_if.master bus
);

   localparam int unsigned IDX_W = ADDR_W + 1;
   localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

   state_e             state_q, state_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [TMO_W-1:0]   tmo_q, tmo_d;
   logic               in_ready_q, in_ready_d;
   logic               cpu_hold_q, cpu_hold_d;
   logic               done_q, done_d;
   logic               err_q, err_d;

   logic               accept_c;
   logic               asm_clear_c;
   logic               asm_valid_c;
   logic [LEN_W-1:0]   len_full_c;
   logic               asm_word_ready;
   logic [WORD_W-1:0]  asm_word;
   logic [CSUM_W-1:0]  asm_csum;
   logic               asm_last_lane_c;

   assign accept_c   = bus.in_valid & in_ready_q;
   assign len_full_c = {bus.in_data, len_q[BYTE_W-1:0]};

   imem_loader_asm u_asm (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear       (asm_clear_c),
      .byte_valid  (asm_valid_c),
      .byte_data   (bus.in_data),
      .word_ready  (asm_word_ready),
      .word        (asm_word),
      .csum        (asm_csum),
      .last_lane_c (asm_last_lane_c)
   );

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      idx_d       = idx_q;
      tmo_d       = tmo_q;
      done_d      = done_q;
      err_d       = err_q;
      asm_clear_c = 1'b0;
      asm_valid_c = 1'b0;

      if (asm_word_ready) idx_d = idx_q + IDX_W'(1);

      // Idle-gap counter only runs inside a frame; any accepted byte restarts it.
      if (in_frame(state_q)) begin
         tmo_d = accept_c ? '0 : tmo_q + TMO_W'(1);
      end

      unique case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (bus.start) begin
               state_d     = ST_LEN_LO;
               len_d       = '0;
               idx_d       = '0;
               tmo_d       = '0;
               done_d      = 1'b0;
               err_d       = 1'b0;
               asm_clear_c = 1'b1;
            end
         end
         ST_LEN_LO: begin
            if (accept_c) begin
               len_d   = {len_q[LEN_W-1:BYTE_W], bus.in_data};
               state_d = ST_LEN_HI;
            end
         end
         ST_LEN_HI: begin
            if (accept_c) begin
               len_d = len_full_c;
               if (len_full_c == '0 || len_full_c > LEN_W'(DEPTH)) begin
                  state_d = ST_ERR;
                  err_d   = 1'b1;
               end else begin
                  state_d = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (accept_c) begin
               asm_valid_c = 1'b1;
               // idx_q already names the word completed by this byte.
               if (asm_last_lane_c && LEN_W'(idx_q) == len_q - LEN_W'(1)) begin
                  state_d = ST_CSUM;
               end
            end
         end
         ST_CSUM: begin
            if (accept_c) begin
               if (bus.in_data == asm_csum) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_ERR;
                  err_d   = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (in_frame(state_q) && !accept_c && tmo_q == TMO_W'(TIMEOUT - 1)) begin
         state_d = ST_ERR;
         err_d   = 1'b1;
      end

      in_ready_d = in_frame(state_d);
      cpu_hold_d = in_frame(state_d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         len_q      <= '0;
         idx_q      <= '0;
         tmo_q      <= '0;
         in_ready_q <= 1'b0;
         cpu_hold_q <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         idx_q      <= idx_d;
         tmo_q      <= tmo_d;
         in_ready_q <= in_ready_d;
         cpu_hold_q <= cpu_hold_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign bus.in_ready   = in_ready_q;
   assign bus.cpu_hold   = cpu_hold_q;
   assign bus.load_done  = done_q;
   assign bus.load_err   = err_q;
   assign bus.write_en   = asm_word_ready;
   assign bus.write_addr = ADDR_W'(idx_q);
   assign bus.write_data = asm_word;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes and status snapshots are
// queued by the stimulus thread and checked by a negedge monitor.
module tb_imem_loader;
   import imem_loader_pkg::*;

   localparam int unsigned ADDR_W  = 8;
   localparam int unsigned DEPTH   = 256;
   localparam int unsigned TIMEOUT = 1000;
   localparam int          BUDGET  = 50;

   localparam int K_STAT    = 0;
   localparam int K_DRAIN   = 1;
   localparam int K_EXPIRED = 2;
   localparam int K_RESET   = 3;

   typedef struct {
      int          tid;
      logic [7:0]  addr;
      logic [31:0] data;
   } wr_t;

   typedef struct {
      int   kind;
      int   tid;
      logic done;
      logic err;
      logic hold;
      logic ready;
   } chk_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   imem_loader_if #(.ADDR_W(ADDR_W)) bus();

   imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   wr_t  exp_q[$];
   chk_t chk_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Monitor: every strobe pops an expected write; queued status checks follow.
   always @(negedge clk) begin
      wr_t  e;
      chk_t c;
      if (bus.write_en === 1'b1) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL write_unexpected got addr=%h data=%h required none", bus.write_addr, bus.write_data);
         end else begin
            e = exp_q.pop_front();
            if (bus.write_addr !== e.addr || bus.write_data !== e.data) begin
               n_bad++;
               $display("FAIL write t%0d got addr=%h data=%h required addr=%h data=%h",
                        e.tid, bus.write_addr, bus.write_data, e.addr, e.data);
            end
         end
      end
      while (chk_q.size() > 0) begin
         c = chk_q.pop_front();
         n_cmp++;
         case (c.kind)
            K_STAT: begin
               if (bus.load_done !== c.done || bus.load_err !== c.err ||
                   bus.cpu_hold !== c.hold || bus.in_ready !== c.ready) begin
                  n_bad++;
                  $display("FAIL status t%0d got done=%b err=%b hold=%b ready=%b required %b %b %b %b",
                           c.tid, bus.load_done, bus.load_err, bus.cpu_hold, bus.in_ready,
                           c.done, c.err, c.hold, c.ready);
               end
            end
            K_DRAIN: begin
               if (exp_q.size() != 0) begin
                  n_bad++;
                  $display("FAIL writes_missing t%0d got %0d outstanding required 0", c.tid, exp_q.size());
                  exp_q.delete();
               end
            end
            K_RESET: begin
               if (bus.write_en !== 1'b0 || bus.write_addr !== '0 || bus.write_data !== '0 ||
                   bus.load_done !== 1'b0 || bus.load_err !== 1'b0 ||
                   bus.cpu_hold !== 1'b0 || bus.in_ready !== 1'b0) begin
                  n_bad++;
                  $display("FAIL reset_state t%0d got en=%b addr=%h data=%h done=%b err=%b hold=%b ready=%b required all 0",
                           c.tid, bus.write_en, bus.write_addr, bus.write_data,
                           bus.load_done, bus.load_err, bus.cpu_hold, bus.in_ready);
               end
            end
            default: begin
               n_bad++;
               $display("FAIL handshake_wait t%0d got no in_ready within %0d cycles required accept", c.tid, BUDGET);
            end
         endcase
      end
   end

   task automatic push_chk(input int kind, input int tid, input logic d, input logic e,
                           input logic h, input logic r);
      chk_t c;
      c.kind = kind; c.tid = tid; c.done = d; c.err = e; c.hold = h; c.ready = r;
      chk_q.push_back(c);
   endtask

   task automatic expect_stat(input int tid, input logic d, input logic e, input logic h, input logic r);
      push_chk(K_STAT, tid, d, e, h, r);
   endtask

   task automatic expect_write(input int tid, input logic [7:0] a, input logic [31:0] d);
      wr_t w;
      w.tid = tid; w.addr = a; w.data = d;
      exp_q.push_back(w);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      cyc(1);
      bus.start = 1'b0;
   endtask

   task automatic send_byte(input int tid, input logic [7:0] b);
      logic ok;
      ok = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      for (int i = 0; i < BUDGET && !ok; i++) begin
         @(negedge clk);
         ok = bus.in_ready;
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      if (!ok) push_chk(K_EXPIRED, tid, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic send_word(input int tid, input logic [31:0] w, input int gap);
      for (int l = 0; l < 4; l++) begin
         send_byte(tid, w[8*l +: 8]);
         if (gap > 0) cyc($urandom_range(gap, 0));
      end
   endtask

   task automatic run_frame(input int tid, input logic [31:0] w[$], input logic flip, input int gap);
      logic [15:0] n;
      logic [7:0]  cs;
      n  = 16'(w.size());
      cs = 8'h00;
      pulse_start();
      expect_stat(tid, 1'b0, 1'b0, 1'b1, 1'b1);
      send_byte(tid, n[7:0]);
      send_byte(tid, n[15:8]);
      foreach (w[i]) begin
         expect_write(tid, 8'(i), w[i]);
         cs = cs ^ w[i][7:0] ^ w[i][15:8] ^ w[i][23:16] ^ w[i][31:24];
         send_word(tid, w[i], gap);
      end
      expect_stat(tid, 1'b0, 1'b0, 1'b1, 1'b1);
      send_byte(tid, flip ? ~cs : cs);
      expect_stat(tid, !flip, flip, 1'b0, 1'b0);
      cyc(2);
      push_chk(K_DRAIN, tid, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic bad_len(input int tid, input logic [15:0] n);
      pulse_start();
      send_byte(tid, n[7:0]);
      send_byte(tid, n[15:8]);
      expect_stat(tid, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc(4);
      expect_stat(tid, 1'b0, 1'b1, 1'b0, 1'b0);
      push_chk(K_DRAIN, tid, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got no finish required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] fr[$];
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;

      // t0: reset state
      cyc(3);
      push_chk(K_RESET, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      cyc(2);
      push_chk(K_RESET, 0, 1'b0, 1'b0, 1'b0, 1'b0);

      // t1: two words, good checksum (0x31)
      fr = {32'h0000_0013, 32'hDEAD_BEEF};
      run_frame(1, fr, 1'b0, 0);

      // t2: same frame, checksum inverted
      run_frame(2, fr, 1'b1, 0);

      // t3/t4: illegal lengths
      bad_len(3, 16'd0);
      bad_len(4, 16'd257);

      // t5: full memory with random gaps between bytes
      fr.delete();
      for (int i = 0; i < 256; i++) fr.push_back({8'(i) ^ 8'hA5, 8'(255 - i), 8'(i), 8'h37});
      run_frame(5, fr, 1'b0, 3);

      // t6: stall mid-word until timeout
      pulse_start();
      send_byte(6, 8'h01);
      send_byte(6, 8'h00);
      send_byte(6, 8'h11);
      send_byte(6, 8'h22);
      cyc(TIMEOUT - 5);
      expect_stat(6, 1'b0, 1'b0, 1'b1, 1'b1);
      cyc(10);
      expect_stat(6, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc(20);
      push_chk(K_DRAIN, 6, 1'b0, 1'b0, 1'b0, 1'b0);

      // t7: reset after six payload bytes, then a clean reload
      pulse_start();
      send_byte(7, 8'h02);
      send_byte(7, 8'h00);
      expect_write(7, 8'h00, 32'hCAFE_F00D);
      send_word(7, 32'hCAFE_F00D, 0);
      send_byte(7, 8'h55);
      send_byte(7, 8'h66);
      rst_n = 1'b0;
      #1;
      push_chk(K_RESET, 7, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(3);
      push_chk(K_DRAIN, 7, 1'b0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      cyc(2);
      push_chk(K_RESET, 7, 1'b0, 1'b0, 1'b0, 1'b0);
      fr = {32'h1234_5678, 32'h0000_ABCD};
      run_frame(8, fr, 1'b0, 1);

      cyc(5);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
